// File: rtl/rtc_pkg.sv
// Shared constants for the RTC read sweep: register map, per-slot masks and ranges,
// result field widths, the packed result set and the FSM state codes.
package rtc_pkg;

    localparam logic [7:0] RTC_SEG   = 8'h21;
    localparam logic [7:0] RTC_MIN   = 8'h22;
    localparam logic [7:0] RTC_HORA  = 8'h23;
    localparam logic [7:0] RTC_DIA   = 8'h24;
    localparam logic [7:0] RTC_MES   = 8'h25;
    localparam logic [7:0] RTC_ANO   = 8'h26;
    localparam logic [7:0] RTC_TMR_S = 8'h41;
    localparam logic [7:0] RTC_TMR_M = 8'h42;
    localparam logic [7:0] RTC_TMR_H = 8'h43;

    // Entry [0] is the first register read in a sweep.
    localparam logic [8:0][7:0] RTC_ADDR = {RTC_TMR_H, RTC_TMR_M, RTC_TMR_S, RTC_ANO, RTC_MES,
                                            RTC_DIA, RTC_HORA, RTC_MIN, RTC_SEG};
    localparam logic [8:0][7:0] RTC_MASK = {8'h3F, 8'h7F, 8'h7F, 8'hFF, 8'h1F,
                                            8'h3F, 8'h3F, 8'h7F, 8'h7F};
    localparam logic [8:0][6:0] RTC_MIN_V = {7'd0, 7'd0, 7'd0, 7'd0, 7'd1,
                                             7'd1, 7'd0, 7'd0, 7'd0};
    localparam logic [8:0][6:0] RTC_MAX_V = {7'd23, 7'd59, 7'd59, 7'd99, 7'd12,
                                             7'd31, 7'd23, 7'd59, 7'd59};

    localparam int W_SEG  = 6;
    localparam int W_MIN  = 6;
    localparam int W_HORA = 5;
    localparam int W_DIA  = 5;
    localparam int W_MES  = 4;
    localparam int W_ANO  = 7;

    typedef struct packed {
        logic [W_SEG-1:0]  seg;
        logic [W_MIN-1:0]  min;
        logic [W_HORA-1:0] hora;
        logic [W_DIA-1:0]  dia;
        logic [W_MES-1:0]  mes;
        logic [W_ANO-1:0]  ano;
        logic [W_SEG-1:0]  t_seg;
        logic [W_MIN-1:0]  t_min;
        logic [W_HORA-1:0] t_hora;
    } rtc_regs_t;

    typedef logic [2:0] rtc_state_t;
    localparam rtc_state_t ST_IDLE   = 3'd0;
    localparam rtc_state_t ST_ADDR   = 3'd1;
    localparam rtc_state_t ST_GAP1   = 3'd2;
    localparam rtc_state_t ST_DATA   = 3'd3;
    localparam rtc_state_t ST_GAP2   = 3'd4;
    localparam rtc_state_t ST_COMMIT = 3'd5;

endpackage

// File: rtl/rtc_lectura_if.sv
// Control, multiplexed bus and result signals of the RTC read master.
interface rtc_lectura_if;
    import rtc_pkg::*;

    logic              start;
    logic              busy;
    logic              done;
    logic              valid;
    logic              bcd_err;
    logic              cs_n;
    logic              rd_n;
    logic              wr_n;
    logic              a_d;
    logic [7:0]        ad_out;
    logic              ad_oe;
    logic [7:0]        ad_in;
    logic [W_SEG-1:0]  rd_stime_s;
    logic [W_MIN-1:0]  rd_stime_m;
    logic [W_HORA-1:0] rd_stime_h;
    logic [W_DIA-1:0]  rd_date_d;
    logic [W_MES-1:0]  rd_date_m;
    logic [W_ANO-1:0]  rd_date_a;
    logic [W_SEG-1:0]  rd_timer_s;
    logic [W_MIN-1:0]  rd_timer_m;
    logic [W_HORA-1:0] rd_timer_h;

    modport master (
        input  start, ad_in,
        output busy, done, valid, bcd_err, cs_n, rd_n, wr_n, a_d, ad_out, ad_oe,
               rd_stime_s, rd_stime_m, rd_stime_h, rd_date_d, rd_date_m, rd_date_a,
               rd_timer_s, rd_timer_m, rd_timer_h
    );

    modport slave (
        output start, ad_in,
        input  busy, done, valid, bcd_err, cs_n, rd_n, wr_n, a_d, ad_out, ad_oe,
               rd_stime_s, rd_stime_m, rd_stime_h, rd_date_d, rd_date_m, rd_date_a,
               rd_timer_s, rd_timer_m, rd_timer_h
    );

endinterface

// File: rtl/bcd_a_bin.sv
// Two-digit BCD to binary with digit and range validation; a rejected value reads as 0.
module bcd_a_bin (
    input  logic [7:0] bcd_i,
    input  logic [6:0] min_i,
    input  logic [6:0] max_i,
    output logic [6:0] bin_o,
    output logic       err_o
);
    logic [3:0] tens_s;
    logic [3:0] units_s;
    logic [7:0] val_s;

    always_comb begin
        tens_s  = bcd_i[7:4];
        units_s = bcd_i[3:0];
        val_s   = ({4'd0, tens_s} * 8'd10) + {4'd0, units_s};
        err_o   = (tens_s > 4'd9) || (units_s > 4'd9) ||
                  (val_s < {1'b0, min_i}) || (val_s > {1'b0, max_i});
        if (err_o) begin
            bin_o = 7'd0;
        end else begin
            bin_o = val_s[6:0];
        end
    end

endmodule

// File: rtl/rtc_lectura.sv
// RTC read master: sweeps nine BCD registers over the multiplexed bus and commits
// the converted set atomically to the rd_* outputs.
module rtc_lectura
    import rtc_pkg::*;
#(
    parameter int T_CYC = 4
) (
    input  logic          clk,
    input  logic          reset,
    rtc_lectura_if.master bus
);
    localparam int PW = $clog2(T_CYC);
    localparam logic [PW-1:0] PH_LAST = PW'(T_CYC - 1);

    rtc_state_t    state_q, state_d;
    logic [PW-1:0] phase_q, phase_d, phase_inc_s;
    logic [3:0]    idx_q, idx_d;
    logic          phase_last_s, last_idx_s, launch_s, sample_s, commit_s;
    rtc_regs_t     shadow_q, shadow_d, rd_q;
    logic          err_acc_q, err_acc_d;
    logic [6:0]    conv_bin_s;
    logic          conv_err_s;
    logic          cs_n_d, rd_n_d, wr_n_d, a_d_d, ad_oe_d;
    logic [7:0]    ad_out_d;
    logic          cs_n_q, rd_n_q, wr_n_q, a_d_q, ad_oe_q;
    logic [7:0]    ad_out_q;
    logic          busy_q, done_q, valid_q, bcd_err_q;

    assign phase_last_s = (phase_q == PH_LAST);
    assign phase_inc_s  = phase_last_s ? '0 : phase_q + PW'(1);
    assign last_idx_s   = (idx_q == 4'd8);
    assign launch_s     = (state_q == ST_IDLE) && bus.start;
    assign sample_s     = (state_q == ST_DATA) && phase_last_s;
    assign commit_s     = (state_q == ST_GAP2) && phase_last_s && last_idx_s;

    bcd_a_bin u_conv (
        .bcd_i (bus.ad_in & RTC_MASK[idx_q]),
        .min_i (RTC_MIN_V[idx_q]),
        .max_i (RTC_MAX_V[idx_q]),
        .bin_o (conv_bin_s),
        .err_o (conv_err_s)
    );

    // Sequencer next state: four equal phases per register, one commit cycle per sweep.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_ADDR;
                    phase_d = '0;
                    idx_d   = 4'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ADDR: begin
                phase_d = phase_inc_s;
                state_d = phase_last_s ? ST_GAP1 : ST_ADDR;
            end
            ST_GAP1: begin
                phase_d = phase_inc_s;
                state_d = phase_last_s ? ST_DATA : ST_GAP1;
            end
            ST_DATA: begin
                phase_d = phase_inc_s;
                state_d = phase_last_s ? ST_GAP2 : ST_DATA;
            end
            ST_GAP2: begin
                phase_d = phase_inc_s;
                if (phase_last_s && last_idx_s) begin
                    state_d = ST_COMMIT;
                end else if (phase_last_s) begin
                    state_d = ST_ADDR;
                    idx_d   = idx_q + 4'd1;
                end else begin
                    state_d = ST_GAP2;
                end
            end
            ST_COMMIT: begin
                state_d = ST_IDLE;
                phase_d = '0;
            end
            default: begin
                state_d = ST_IDLE;
                phase_d = '0;
                idx_d   = 4'd0;
            end
        endcase
    end

    // Bus strobes are decoded from the next state so the registered pins line up with it.
    always_comb begin
        cs_n_d   = 1'b1;
        rd_n_d   = 1'b1;
        wr_n_d   = 1'b1;
        a_d_d    = 1'b1;
        ad_oe_d  = 1'b0;
        ad_out_d = ad_out_q;
        case (state_d)
            ST_ADDR: begin
                cs_n_d   = 1'b0;
                wr_n_d   = 1'b0;
                a_d_d    = 1'b0;
                ad_oe_d  = 1'b1;
                ad_out_d = RTC_ADDR[idx_d];
            end
            ST_GAP1: begin
                a_d_d   = 1'b0;
                ad_oe_d = 1'b1;
            end
            ST_DATA: begin
                cs_n_d = 1'b0;
                rd_n_d = 1'b0;
            end
            default: begin
                cs_n_d = 1'b1;
            end
        endcase
    end

    // Shadow slot update at the end of each data phase; error flag restarts per sweep.
    always_comb begin
        shadow_d  = shadow_q;
        err_acc_d = err_acc_q;
        if (launch_s) begin
            err_acc_d = 1'b0;
        end else if (sample_s) begin
            err_acc_d = err_acc_q | conv_err_s;
            case (idx_q)
                4'd0:    shadow_d.seg    = conv_bin_s[W_SEG-1:0];
                4'd1:    shadow_d.min    = conv_bin_s[W_MIN-1:0];
                4'd2:    shadow_d.hora   = conv_bin_s[W_HORA-1:0];
                4'd3:    shadow_d.dia    = conv_bin_s[W_DIA-1:0];
                4'd4:    shadow_d.mes    = conv_bin_s[W_MES-1:0];
                4'd5:    shadow_d.ano    = conv_bin_s[W_ANO-1:0];
                4'd6:    shadow_d.t_seg  = conv_bin_s[W_SEG-1:0];
                4'd7:    shadow_d.t_min  = conv_bin_s[W_MIN-1:0];
                4'd8:    shadow_d.t_hora = conv_bin_s[W_HORA-1:0];
                default: shadow_d        = shadow_q;
            endcase
        end else begin
            shadow_d = shadow_q;
        end
    end

    // Sequencer and shadow state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            phase_q   <= '0;
            idx_q     <= 4'd0;
            shadow_q  <= '0;
            err_acc_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            idx_q     <= idx_d;
            shadow_q  <= shadow_d;
            err_acc_q <= err_acc_d;
        end
    end

    // Output registers; results, done and bcd_err all change on the commit edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cs_n_q    <= 1'b1;
            rd_n_q    <= 1'b1;
            wr_n_q    <= 1'b1;
            a_d_q     <= 1'b1;
            ad_oe_q   <= 1'b0;
            ad_out_q  <= 8'h00;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            valid_q   <= 1'b0;
            bcd_err_q <= 1'b0;
            rd_q      <= '0;
        end else begin
            cs_n_q   <= cs_n_d;
            rd_n_q   <= rd_n_d;
            wr_n_q   <= wr_n_d;
            a_d_q    <= a_d_d;
            ad_oe_q  <= ad_oe_d;
            ad_out_q <= ad_out_d;
            busy_q   <= (state_d != ST_IDLE);
            done_q   <= commit_s;
            if (commit_s) begin
                rd_q      <= shadow_q;
                bcd_err_q <= err_acc_q;
                valid_q   <= 1'b1;
            end else begin
                rd_q      <= rd_q;
                bcd_err_q <= bcd_err_q;
                valid_q   <= valid_q;
            end
        end
    end

    assign bus.cs_n       = cs_n_q;
    assign bus.rd_n       = rd_n_q;
    assign bus.wr_n       = wr_n_q;
    assign bus.a_d        = a_d_q;
    assign bus.ad_oe      = ad_oe_q;
    assign bus.ad_out     = ad_out_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.valid      = valid_q;
    assign bus.bcd_err    = bcd_err_q;
    assign bus.rd_stime_s = rd_q.seg;
    assign bus.rd_stime_m = rd_q.min;
    assign bus.rd_stime_h = rd_q.hora;
    assign bus.rd_date_d  = rd_q.dia;
    assign bus.rd_date_m  = rd_q.mes;
    assign bus.rd_date_a  = rd_q.ano;
    assign bus.rd_timer_s = rd_q.t_seg;
    assign bus.rd_timer_m = rd_q.t_min;
    assign bus.rd_timer_h = rd_q.t_hora;

endmodule

// File: tb/tb_rtc_lectura.sv
// Bench for rtc_lectura: RTC bus model and protocol monitor, with results compared
// against a decimal decoding model of the nine registers.
module tb_rtc_lectura;
    localparam int T     = 4;
    localparam int SWEEP = 36 * T;
    localparam logic [7:0] ADDRS [9] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43};
    localparam int MSK [9] = '{127, 127, 63, 63, 31, 255, 127, 127, 63};
    localparam int LO  [9] = '{0, 0, 0, 1, 1, 0, 0, 0, 0};
    localparam int HI  [9] = '{59, 59, 23, 31, 12, 99, 59, 59, 23};
    localparam int WID [9] = '{6, 6, 5, 5, 4, 7, 6, 6, 5};

    logic clk   = 1'b0;
    logic reset = 1'b0;
    rtc_lectura_if bus();

    rtc_lectura #(.T_CYC(T)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    logic [7:0] mem [9];
    int got [9];

    int addr_cnt = 0, viol_cnt = 0, done_cnt = 0, done_cyc = 0;
    logic [7:0] addr_log [$];
    int rd_len_log [$];
    int wr_len_log [$];
    int done_log [$];
    bit wr_prev = 1'b0, rd_prev = 1'b0, wr_now, rd_now;
    int wr_run = 0, rd_run = 0;
    logic [7:0] cur_addr = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] bus_lookup(input logic [7:0] a);
        for (int i = 0; i < 9; i++) if (ADDRS[i] == a) return mem[i];
        return 8'hEE;
    endfunction

    // RTC model and protocol monitor, sampled mid-cycle.
    always @(negedge clk) begin
        wr_now = (bus.cs_n === 1'b0) && (bus.wr_n === 1'b0);
        rd_now = (bus.cs_n === 1'b0) && (bus.rd_n === 1'b0);
        if (wr_now && !wr_prev) begin
            addr_cnt++;
            cur_addr = bus.ad_out;
            addr_log.push_back(bus.ad_out);
            bus.ad_in = bus_lookup(bus.ad_out);
            wr_run = 0;
        end
        if (wr_now) wr_run++;
        if (!wr_now && wr_prev) wr_len_log.push_back(wr_run);
        if (rd_now && !rd_prev) rd_run = 0;
        if (rd_now) rd_run++;
        if (!rd_now && rd_prev) rd_len_log.push_back(rd_run);
        if (wr_now && (bus.ad_oe !== 1'b1 || bus.a_d !== 1'b0)) viol_cnt++;
        if (bus.rd_n === 1'b0 && (bus.ad_oe !== 1'b0 || bus.a_d !== 1'b1 || bus.cs_n !== 1'b0)) viol_cnt++;
        if (bus.rd_n === 1'b0 && bus.wr_n === 1'b0) viol_cnt++;
        if (bus.ad_oe === 1'b1 && bus.a_d !== 1'b0) viol_cnt++;
        if (bus.a_d === 1'b0 && bus.ad_out !== cur_addr) viol_cnt++;
        if (bus.cs_n === 1'b0 && !wr_now && !rd_now) viol_cnt++;
        if (bus.done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
            done_log.push_back(cyc);
        end
        wr_prev = wr_now;
        rd_prev = rd_now;
    end

    function automatic void snap();
        got[0] = int'(bus.rd_stime_s); got[1] = int'(bus.rd_stime_m); got[2] = int'(bus.rd_stime_h);
        got[3] = int'(bus.rd_date_d);  got[4] = int'(bus.rd_date_m);  got[5] = int'(bus.rd_date_a);
        got[6] = int'(bus.rd_timer_s); got[7] = int'(bus.rd_timer_m); got[8] = int'(bus.rd_timer_h);
    endfunction

    // Decimal reading of a register byte: masked, two digits, range-checked, 0 if rejected.
    function automatic void model_slot(input int i, input logic [7:0] b, output int val, output bit err);
        int m, t, u, v;
        m = int'(b) & MSK[i];
        t = m / 16;
        u = m % 16;
        v = t * 10 + u;
        err = (t > 9) || (u > 9) || (v < LO[i]) || (v > HI[i]);
        val = err ? 0 : v % (1 << WID[i]);
    endfunction

    task automatic do_sweep(output int lat, output bit tmo);
        int n0, s_edge;
        @(negedge clk); #1;
        bus.start = 1'b1;
        s_edge = cyc + 1;
        n0 = done_cnt;
        @(negedge clk); #1;
        bus.start = 1'b0;
        for (int i = 0; i < SWEEP + 20 && done_cnt == n0; i++) begin
            @(negedge clk); #1;
        end
        tmo = (done_cnt == n0);
        lat = tmo ? -1 : done_cyc - s_edge;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        checks++; if ({bus.cs_n, bus.rd_n, bus.wr_n, bus.a_d} !== 4'b1111) begin failures++; $display("FAIL reset_strobes: got %b exp 1111", {bus.cs_n, bus.rd_n, bus.wr_n, bus.a_d}); end
        checks++; if ({bus.ad_oe, bus.ad_out} !== 9'd0) begin failures++; $display("FAIL reset_ad: got oe=%b out=%h exp 0/00", bus.ad_oe, bus.ad_out); end
        checks++; if ({bus.busy, bus.done, bus.valid, bus.bcd_err} !== 4'b0000) begin failures++; $display("FAIL reset_status: got %b exp 0000", {bus.busy, bus.done, bus.valid, bus.bcd_err}); end
        snap();
        for (int i = 0; i < 9; i++) begin
            checks++; if (got[i] !== 0) begin failures++; $display("FAIL reset_field%0d: got %0d exp 0", i, got[i]); end
        end
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL idle_busy: got %b exp 0", bus.busy); end
    endtask

    task automatic check_fields(input string tag, input logic [7:0] src [9]);
        int ev; bit ee; bit any_err;
        any_err = 1'b0;
        snap();
        for (int i = 0; i < 9; i++) begin
            model_slot(i, src[i], ev, ee);
            any_err |= ee;
            checks++; if (got[i] !== ev) begin failures++; $display("FAIL %s_field%0d: got %0d exp %0d (byte %h)", tag, i, got[i], ev, src[i]); end
        end
        checks++; if (bus.bcd_err !== any_err) begin failures++; $display("FAIL %s_bcd_err: got %b exp %b", tag, bus.bcd_err, any_err); end
        checks++; if (bus.valid !== 1'b1) begin failures++; $display("FAIL %s_valid: got %b exp 1", tag, bus.valid); end
    endtask

    task automatic test_sweep();
        int lat, a0, r0, w0, v0; bit tmo;
        mem = '{8'h45, 8'h30, 8'h23, 8'h31, 8'h12, 8'h99, 8'h05, 8'h10, 8'h01};
        a0 = addr_log.size(); r0 = rd_len_log.size(); w0 = wr_len_log.size(); v0 = viol_cnt;
        do_sweep(lat, tmo);
        checks++; if (tmo) begin failures++; $display("FAIL sweep_timeout: no done within %0d cycles", SWEEP + 20); end
        checks++; if (lat !== SWEEP) begin failures++; $display("FAIL done_latency: got %0d exp %0d", lat, SWEEP); end
        snap();
        checks++; if (got !== '{45, 30, 23, 31, 12, 99, 5, 10, 1}) begin failures++; $display("FAIL sweep_values: got %0d %0d %0d %0d %0d %0d %0d %0d %0d", got[0], got[1], got[2], got[3], got[4], got[5], got[6], got[7], got[8]); end
        check_fields("sweep", mem);
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL busy_at_done: got %b exp 1", bus.busy); end
        checks++; if (addr_log.size() - a0 !== 9) begin failures++; $display("FAIL addr_phases: got %0d exp 9", addr_log.size() - a0); end
        for (int i = 0; i < 9 && a0 + i < addr_log.size(); i++) begin
            checks++; if (addr_log[a0 + i] !== ADDRS[i]) begin failures++; $display("FAIL addr%0d: got %h exp %h", i, addr_log[a0 + i], ADDRS[i]); end
        end
        checks++; if (rd_len_log.size() - r0 !== 9 || wr_len_log.size() - w0 !== 9) begin failures++; $display("FAIL strobe_count: got rd=%0d wr=%0d exp 9", rd_len_log.size() - r0, wr_len_log.size() - w0); end
        for (int i = r0; i < rd_len_log.size(); i++) begin
            checks++; if (rd_len_log[i] !== T) begin failures++; $display("FAIL rd_len%0d: got %0d exp %0d", i - r0, rd_len_log[i], T); end
        end
        for (int i = w0; i < wr_len_log.size(); i++) begin
            checks++; if (wr_len_log[i] !== T) begin failures++; $display("FAIL wr_len%0d: got %0d exp %0d", i - w0, wr_len_log[i], T); end
        end
        checks++; if (viol_cnt - v0 !== 0) begin failures++; $display("FAIL bus_protocol: got %0d violations exp 0", viol_cnt - v0); end
        @(negedge clk); #1;
        checks++; if ({bus.done, bus.busy} !== 2'b00) begin failures++; $display("FAIL after_done: got done=%b busy=%b exp 0/0", bus.done, bus.busy); end
    endtask

    task automatic test_bcd_err();
        int lat; bit tmo;
        mem = '{8'h12, 8'h34, 8'h2A, 8'h15, 8'h13, 8'h07, 8'h59, 8'h00, 8'h23};
        do_sweep(lat, tmo);
        checks++; if (tmo) begin failures++; $display("FAIL err_timeout: no done"); end
        check_fields("err", mem);
        checks++; if ({bus.rd_stime_h, bus.rd_date_m, bus.bcd_err} !== 10'b00000_0000_1) begin failures++; $display("FAIL err_slots: got h=%0d m=%0d err=%b exp 0 0 1", bus.rd_stime_h, bus.rd_date_m, bus.bcd_err); end
        mem = '{8'h12, 8'h34, 8'h22, 8'h15, 8'h11, 8'h07, 8'h59, 8'h00, 8'h23};
        do_sweep(lat, tmo);
        checks++; if (tmo) begin failures++; $display("FAIL clean_timeout: no done"); end
        check_fields("clean", mem);
    endtask

    task automatic test_random();
        int lat, v; bit tmo; logic [7:0] b;
        for (int s = 0; s < 5; s++) begin
            for (int i = 0; i < 9; i++) begin
                v = int'($urandom_range(LO[i], HI[i]));
                if ($urandom_range(0, 3) == 0) b = 8'($urandom);
                else b = 8'((v / 10) * 16 + v % 10) | (8'($urandom) & ~8'(MSK[i]));
                mem[i] = b;
            end
            do_sweep(lat, tmo);
            checks++; if (tmo) begin failures++; $display("FAIL rand_timeout: sweep %0d", s); end
            check_fields("rand", mem);
        end
    endtask

    task automatic test_restart_ignored();
        int n0, a0;
        n0 = done_cnt; a0 = addr_cnt;
        @(negedge clk); #1; bus.start = 1'b1;
        @(negedge clk); #1; bus.start = 1'b0;
        for (int c = 2; c <= SWEEP + 20; c++) begin
            @(negedge clk); #1;
            bus.start = (c == 10 || c == 80);
        end
        bus.start = 1'b0;
        checks++; if (done_cnt - n0 !== 1) begin failures++; $display("FAIL restart_done: got %0d pulses exp 1", done_cnt - n0); end
        checks++; if (addr_cnt - a0 !== 9) begin failures++; $display("FAIL restart_addr: got %0d exp 9", addr_cnt - a0); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL restart_busy: got %b exp 0", bus.busy); end
    endtask

    task automatic test_reset_midsweep();
        int n0;
        checks++; if (bus.valid !== 1'b1) begin failures++; $display("FAIL pre_valid: got %b exp 1", bus.valid); end
        @(negedge clk); #1; bus.start = 1'b1;
        @(negedge clk); #1; bus.start = 1'b0;
        repeat (59) @(negedge clk);
        #1;
        checks++; if ({bus.cs_n, bus.rd_n} !== 2'b00) begin failures++; $display("FAIL pre_reset_read: got cs_n=%b rd_n=%b exp 0/0", bus.cs_n, bus.rd_n); end
        #1; reset = 1'b0; #1;
        checks++; if ({bus.cs_n, bus.rd_n, bus.wr_n, bus.a_d, bus.ad_oe} !== 5'b11110) begin failures++; $display("FAIL async_release: got %b exp 11110", {bus.cs_n, bus.rd_n, bus.wr_n, bus.a_d, bus.ad_oe}); end
        checks++; if ({bus.busy, bus.valid, bus.done, bus.bcd_err} !== 4'b0000) begin failures++; $display("FAIL async_status: got %b exp 0000", {bus.busy, bus.valid, bus.done, bus.bcd_err}); end
        repeat (2) @(negedge clk);
        #1; reset = 1'b1;
        n0 = done_cnt;
        repeat (SWEEP + 20) @(negedge clk);
        #1;
        checks++; if (done_cnt !== n0) begin failures++; $display("FAIL no_done_after_reset: got %0d pulses exp 0", done_cnt - n0); end
        snap();
        for (int i = 0; i < 9; i++) begin
            checks++; if (got[i] !== 0) begin failures++; $display("FAIL post_reset_field%0d: got %0d exp 0", i, got[i]); end
        end
        checks++; if ({bus.valid, bus.busy} !== 2'b00) begin failures++; $display("FAIL post_reset_status: got valid=%b busy=%b exp 0/0", bus.valid, bus.busy); end
    endtask

    task automatic test_back_to_back();
        int n0; bit tmo;
        n0 = done_cnt;
        @(negedge clk); #1; bus.start = 1'b1;
        for (int i = 0; i < 4 * (SWEEP + 2) && done_cnt < n0 + 3; i++) begin
            @(negedge clk); #1;
        end
        bus.start = 1'b0;
        tmo = (done_cnt < n0 + 3);
        checks++; if (tmo) begin failures++; $display("FAIL b2b_timeout: got %0d dones exp 3", done_cnt - n0); end
        if (!tmo) begin
            for (int j = 1; j < 3; j++) begin
                checks++; if (done_log[n0 + j] - done_log[n0 + j - 1] !== SWEEP + 2) begin failures++; $display("FAIL b2b_period%0d: got %0d exp %0d", j, done_log[n0 + j] - done_log[n0 + j - 1], SWEEP + 2); end
            end
        end
        for (int i = 0; i < SWEEP + 20 && bus.busy !== 1'b0; i++) begin
            @(negedge clk); #1;
        end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL b2b_stop: got busy=%b exp 0", bus.busy); end
    endtask

    initial begin
        bus.start = 1'b0;
        test_reset();
        test_sweep();
        test_bcd_err();
        test_random();
        test_restart_ignored();
        test_reset_midsweep();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rtc_lectura.md
# rtc_lectura

Read-side bus master for the external RTC. Runs a sweep over the nine time, date and timer registers on the multiplexed address/data bus and converts each BCD byte to binary. The results use the same field widths as the up/down setting counters, so the display and compare logic can take either source unchanged. All nine results are committed together, so downstream logic never sees a half-updated time/date set.

## Interface
Parameters:
- T_CYC, 4, clk cycles per bus phase (≥2)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  request one read sweep (level sampled in IDLE)
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse when results are committed
- valid  out  1  set at first commit, cleared only by reset
- bcd_err  out  1  last sweep contained an invalid BCD digit or an out-of-range field
- cs_n, rd_n, wr_n  out  1 each  bus strobes, active-low
- a_d  out  1  0 = address phase, 1 = data phase
- ad_out  out  8  address driven onto the bus
- ad_oe  out  1  pad output enable for ad_out
- ad_in  in  8  bus read-back from the pad
- rd_stime_s, rd_stime_m  out  6 each  seconds, minutes
- rd_stime_h  out  5  hours, 0–23
- rd_date_d  out  5  day, 1–31
- rd_date_m  out  4  month, 1–12
- rd_date_a  out  7  year, 0–99
- rd_timer_s, rd_timer_m  out  6 each; rd_timer_h  out  5

## Operation
- FSM states: IDLE → ADDR → GAP1 → DATA → GAP2 → (next index: ADDR | last index: COMMIT) → IDLE.
- Each bus phase lasts T_CYC cycles, counted by phase_cnt 0..T_CYC-1. COMMIT lasts 1 cycle.
- Read order (idx 0–8), address and mask:
  - 0x21 sec, mask 0x7F
  - 0x22 min, mask 0x7F
  - 0x23 hour, mask 0x3F
  - 0x24 day, mask 0x3F
  - 0x25 month, mask 0x1F
  - 0x26 year, mask 0xFF
  - 0x41 timer sec, mask 0x7F
  - 0x42 timer min, mask 0x7F
  - 0x43 timer hour, mask 0x3F
- Bus signals per state:
  - ADDR: cs_n=0, wr_n=0, a_d=0, ad_oe=1, ad_out=addr[idx].
  - GAP1: strobes high, a_d=0, ad_oe=1, ad_out held.
  - DATA: cs_n=0, rd_n=0, a_d=1, ad_oe=0. ad_in is sampled into the shadow slot on phase_cnt = T_CYC-1.
  - GAP2 / IDLE / COMMIT: all strobes high, a_d=1, ad_oe=0.
- Conversion: masked byte → tens*10 + units, truncated to the field width.
  - A nibble > 9 sets err_acc.
  - A value outside the field range also sets err_acc: sec/min ≤59, hour ≤23, day 1–31, month 1–12.
  - A slot with an error stores 0.
- COMMIT:
  - All rd_* outputs load from the shadow registers.
  - bcd_err ← err_acc; done=1; valid=1.
  - err_acc is cleared on entry to ADDR of idx 0.
- start while busy is ignored; there is no queueing.
- start held high in IDLE begins a new sweep on the cycle after COMMIT.
- wr_n is used only as the address latch strobe. This block never writes RTC registers.

## Timing
- Reset values:
  - cs_n=rd_n=wr_n=1, a_d=1, ad_oe=0, ad_out=0.
  - busy=0, done=0, valid=0, bcd_err=0.
  - All rd_* = 0; state IDLE.
- start high at edge k (in IDLE) → ADDR and busy=1 from k+1.
- done is high in the cycle at 36*T_CYC+1 after k. rd_* change on the same edge that raises done.
- busy drops together with done's deassertion; the cycle after done is IDLE with busy=0.
- Reset asserted mid-sweep: the bus is released immediately (asynchronously) and all outputs go to their reset values. A partial sweep never reaches rd_*.
- ad_out is stable for the whole of ADDR+GAP1 (2*T_CYC cycles). ad_oe is never high in DATA.

## Structure
- Package rtc_pkg holds:
  - address constants RTC_SEG … RTC_TMR_H
  - the mask array
  - the field-width localparams (6/6/5/5/4/7)
  - the state enum
- Sub-module bcd_a_bin: combinational, 8-bit masked BCD in → 7-bit binary + err out, with min/max range inputs. One instance, time-shared across the slots.
- The top level holds the FSM, phase_cnt, idx, nine shadow registers and the output registers.

## Test plan
- Reset, then start pulse; bus model returns 0x45,0x30,0x23,0x31,0x12,0x99,0x05,0x10,0x01 → done at cycle 145 (T_CYC=4). Outputs 45,30,23,31,12,99,5,10,1; bcd_err=0; valid=1.
- Bus checker on the same sweep: each of the 9 reads shows ADDR with ad_oe=1 and correct address, then DATA with ad_oe=0 and rd_n low for exactly 4 cycles. No cs_n overlap between phases.
- Hour byte 0x2A (invalid nibble) and month 0x13 (out of range) → rd_stime_h=0, rd_date_m=0, bcd_err=1. Next clean sweep → bcd_err=0.
- start re-pulsed at cycles 10 and 80 of a sweep → only one done pulse. Exactly 9 address phases observed.
- reset low at cycle 60 of a second sweep → strobes high and ad_oe=0 immediately. rd_* = 0, valid=0; no done pulse.
- start held high continuously → back-to-back sweeps with done every 36*T_CYC+2 cycles.
